// File: rtl/router_dest_reader_if.sv
// FIFO-facing handshake of one router output port plus the captured-byte
// monitor stream. The reader drives through the master modport; the FIFO
// (or a bench model of it) uses the slave modport.
interface router_dest_reader_if;
    logic       vld_out;
    logic       soft_reset;
    logic [7:0] data_out;
    logic       read_enb;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (
        input  vld_out,
        input  soft_reset,
        input  data_out,
        output read_enb,
        output rx_data,
        output rx_valid
    );

    modport slave (
        output vld_out,
        output soft_reset,
        output data_out,
        input  read_enb,
        input  rx_data,
        input  rx_valid
    );
endinterface

// File: rtl/router_dest_reader.sv
// Destination-side packet reader for one router output port. Waits a
// programmable delay after the FIFO reports data, reads exactly one packet
// (header, L payload bytes, parity), streams each byte to the monitor, checks
// parity and destination address, and keeps good/error packet counters.
module router_dest_reader #(
    parameter logic [1:0] PORT_ID = 2'd0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [5:0]           read_delay,
    router_dest_reader_if.master fifo,
    output logic                 pkt_done,
    output logic                 parity_err,
    output logic                 addr_err,
    output logic                 pkt_abort,
    output logic [5:0]           pkt_len,
    output logic [1:0]           pkt_addr,
    output logic [7:0]           good_count,
    output logic [7:0]           err_count,
    output logic                 busy
);
    localparam int DATA_W = 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_HDR_RD  = 3'd2;
    localparam logic [2:0] S_HDR_CAP = 3'd3;
    localparam logic [2:0] S_BODY    = 3'd4;
    localparam logic [2:0] S_DRAIN   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]        state;
    logic [5:0]        dly_cnt;
    logic [6:0]        rem_cnt;
    logic              read_enb;
    logic              abort;

    // Read-side pipeline: a byte requested in one cycle is on data_out in the next.
    logic              vld_p0;
    logic              hdr_p0;
    logic              last_p0;

    // Capture stage.
    logic [DATA_W-1:0] rx_data_p1;
    logic              vld_p1;
    logic [DATA_W-1:0] xor_p1;
    logic [DATA_W-1:0] par_p1;

    // Error counter never wraps back to a clean-looking value.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A timeout drops the packet in any active state; in DONE the packet completes instead.
    assign abort = fifo.soft_reset && (state != S_IDLE) && (state != S_DONE);

    assign busy          = (state != S_IDLE);
    assign fifo.read_enb = read_enb;
    assign fifo.rx_data  = rx_data_p1;
    assign fifo.rx_valid = vld_p1;

    // Read strobe decoded from the state register; only BODY looks at vld_out.
    always_comb begin
        read_enb = 1'b0;
        case (state)
            S_HDR_RD: read_enb = 1'b1;
            S_BODY:   read_enb = fifo.vld_out;
            default:  read_enb = 1'b0;
        endcase
    end

    // Packet sequencing: delay, header read, bounded body reads, drain, report.
    always_ff @(posedge clock) begin
        if (reset || abort) begin
            state   <= S_IDLE;
            dly_cnt <= '0;
            rem_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable && fifo.vld_out) begin
                        dly_cnt <= read_delay;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dly_cnt == 6'd0) state <= S_HDR_RD;
                    else                 dly_cnt <= dly_cnt - 6'd1;
                end
                S_HDR_RD:  state <= S_HDR_CAP;
                S_HDR_CAP: begin
                    // L payload reads plus the parity read.
                    rem_cnt <= {1'b0, fifo.data_out[7:2]} + 7'd1;
                    state   <= S_BODY;
                end
                S_BODY: begin
                    if (fifo.vld_out) begin
                        rem_cnt <= rem_cnt - 7'd1;
                        if (rem_cnt == 7'd1) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (vld_p0 && last_p0) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stage p0: tag each issued read so the returning byte knows its role.
    always_ff @(posedge clock) begin
        if (reset || abort) begin
            vld_p0  <= 1'b0;
            hdr_p0  <= 1'b0;
            last_p0 <= 1'b0;
        end else begin
            vld_p0  <= read_enb;
            hdr_p0  <= (state == S_HDR_RD);
            last_p0 <= (state == S_BODY) && read_enb && (rem_cnt == 7'd1);
        end
    end

    // Stage p1: capture returned bytes, build running parity, latch header fields.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_data_p1 <= '0;
            vld_p1     <= 1'b0;
            xor_p1     <= '0;
            par_p1     <= '0;
            pkt_len    <= '0;
            pkt_addr   <= '0;
        end else if (abort) begin
            vld_p1 <= 1'b0;
            xor_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) rx_data_p1 <= fifo.data_out;
            if (vld_p0 && hdr_p0) begin
                xor_p1   <= fifo.data_out;
                pkt_len  <= fifo.data_out[7:2];
                pkt_addr <= fifo.data_out[1:0];
            end else if (vld_p0 && last_p0) begin
                par_p1 <= fifo.data_out;
            end else if (vld_p0) begin
                xor_p1 <= xor_p1 ^ fifo.data_out;
            end
        end
    end

    // Completion/abort reporting and packet statistics.
    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_done   <= 1'b0;
            pkt_abort  <= 1'b0;
            parity_err <= 1'b0;
            addr_err   <= 1'b0;
            good_count <= '0;
            err_count  <= '0;
        end else begin
            pkt_done  <= (state == S_DONE);
            pkt_abort <= abort;
            if (state == S_DONE) begin
                parity_err <= (par_p1 != xor_p1);
                addr_err   <= (pkt_addr != PORT_ID);
                if ((par_p1 == xor_p1) && (pkt_addr == PORT_ID))
                    good_count <= good_count + 8'd1;
                else
                    err_count <= sat_inc8(err_count);
            end else if (abort) begin
                err_count <= sat_inc8(err_count);
            end
        end
    end
endmodule

// File: tb/tb_router_dest_reader.sv
// Directed bench for router_dest_reader: a queue-based output FIFO model with
// 1-cycle read latency feeds the reader; outputs are sampled on the falling edge.
module tb_router_dest_reader;
    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [5:0] read_delay;
    logic       pkt_done, parity_err, addr_err, pkt_abort, busy;
    logic [5:0] pkt_len;
    logic [1:0] pkt_addr;
    logic [7:0] good_count, err_count;

    router_dest_reader_if ifc ();

    router_dest_reader #(.PORT_ID(2'd1)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .read_delay (read_delay),
        .fifo       (ifc.master),
        .pkt_done   (pkt_done),
        .parity_err (parity_err),
        .addr_err   (addr_err),
        .pkt_abort  (pkt_abort),
        .pkt_len    (pkt_len),
        .pkt_addr   (pkt_addr),
        .good_count (good_count),
        .err_count  (err_count),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_rx[$];
    logic [7:0] rx_log[$];
    int checks = 0;
    int errors = 0;
    int cyc, n_reads, n_done, n_abort, first_vld, first_re;
    logic last_par, last_addr, stall;
    logic s_re, s_rxv, s_done, s_abort, s_par, s_addr, s_busy;
    logic [7:0] s_rxd, s_good, s_err;
    logic [5:0] s_len;
    logic [1:0] s_paddr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, then update the FIFO model after the rising edge.
    task automatic tick();
        @(negedge clock);
        cyc++;
        s_re = ifc.read_enb;   s_rxv = ifc.rx_valid; s_rxd = ifc.rx_data;
        s_done = pkt_done;     s_abort = pkt_abort;  s_par = parity_err;
        s_addr = addr_err;     s_len = pkt_len;      s_paddr = pkt_addr;
        s_good = good_count;   s_err = err_count;    s_busy = busy;
        if (ifc.vld_out && first_vld < 0) first_vld = cyc;
        if (ifc.read_enb) begin
            n_reads++;
            if (first_re < 0) first_re = cyc;
        end
        if (ifc.rx_valid) rx_log.push_back(ifc.rx_data);
        if (pkt_done) begin
            n_done++;
            last_par  = parity_err;
            last_addr = addr_err;
        end
        if (pkt_abort) n_abort++;
        @(posedge clock);
        #1;
        if (s_re && fifo_q.size() != 0) ifc.data_out = fifo_q.pop_front();
        ifc.vld_out = (fifo_q.size() != 0) && !stall;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        enable = 1'b1;
        ifc.soft_reset = 1'b0;
        ifc.vld_out = 1'b0;
        ifc.data_out = 8'h00;
        stall = 1'b0;
        fifo_q.delete();
        tick();
        tick();
        reset = 1'b0;
        n_reads = 0; n_done = 0; n_abort = 0;
        first_vld = -1; first_re = -1;
        last_par = 1'bx; last_addr = 1'bx;
        rx_log.delete();
        exp_rx.delete();
    endtask

    // Header, L payload bytes (first, first+step, ...), then parity (or 0x00 if corrupted).
    task automatic push_pkt(input logic [7:0] hdr, input logic [7:0] first,
                            input logic [7:0] step, input logic bad_par);
        logic [7:0] p, b;
        int len;
        len = int'(hdr[7:2]);
        p = hdr;
        b = first;
        fifo_q.push_back(hdr);
        exp_rx.push_back(hdr);
        for (int i = 0; i < len; i++) begin
            fifo_q.push_back(b);
            exp_rx.push_back(b);
            p = p ^ b;
            b = b + step;
        end
        if (bad_par) p = 8'h00;
        fifo_q.push_back(p);
        exp_rx.push_back(p);
    endtask

    task automatic run_done(input int target, input int budget);
        int b;
        b = 0;
        while (n_done < target && b < budget) begin
            tick();
            b++;
        end
        chk("done_in_budget", 32'(n_done >= target), 1);
    endtask

    initial begin
        int reads1, b;
        logic stalled;
        logic [7:0] nominal [5];
        read_delay = 6'd2;
        cyc = 0;

        // Reset state
        reset_dut();
        chk("rst_busy", busy, 0);
        chk("rst_read_enb", ifc.read_enb, 0);
        chk("rst_rx_valid", ifc.rx_valid, 0);
        chk("rst_good", good_count, 0);
        chk("rst_err", err_count, 0);
        chk("rst_pkt_done", pkt_done, 0);

        // Nominal packet: 0D 11 22 33 and parity 0D^11^22^33 = 0D
        nominal[0] = 8'h0D; nominal[1] = 8'h11; nominal[2] = 8'h22;
        nominal[3] = 8'h33; nominal[4] = 8'h0D;
        read_delay = 6'd2;
        push_pkt(8'h0D, 8'h11, 8'h11, 1'b0);
        ifc.vld_out = 1'b1;
        run_done(1, 100);
        repeat (3) tick();
        chk("nom_latency", first_re - first_vld, 4);
        chk("nom_reads", n_reads, 5);
        chk("nom_rx_count", rx_log.size(), 5);
        for (int i = 0; i < 5 && i < rx_log.size(); i++) chk("nom_rx_byte", rx_log[i], nominal[i]);
        chk("nom_parity_err", last_par, 0);
        chk("nom_addr_err", last_addr, 0);
        chk("nom_good", good_count, 1);
        chk("nom_err", err_count, 0);
        chk("nom_len", pkt_len, 3);
        chk("nom_addr", pkt_addr, 1);
        chk("nom_busy", busy, 0);

        // Parity error
        reset_dut();
        push_pkt(8'h0D, 8'h11, 8'h11, 1'b1);
        ifc.vld_out = 1'b1;
        run_done(1, 100);
        repeat (2) tick();
        chk("par_parity_err", last_par, 1);
        chk("par_addr_err", last_addr, 0);
        chk("par_err", err_count, 1);
        chk("par_good", good_count, 0);

        // Address error: header 0E targets port 2
        reset_dut();
        push_pkt(8'h0E, 8'h11, 8'h11, 1'b0);
        ifc.vld_out = 1'b1;
        run_done(1, 100);
        repeat (2) tick();
        chk("addr_addr_err", last_addr, 1);
        chk("addr_parity_err", last_par, 0);
        chk("addr_err", err_count, 1);
        chk("addr_good", good_count, 0);

        // Timeout during a long delay
        reset_dut();
        read_delay = 6'd40;
        push_pkt(8'h0D, 8'h11, 8'h11, 1'b0);
        ifc.vld_out = 1'b1;
        repeat (31) tick();
        ifc.soft_reset = 1'b1;
        fifo_q.delete();
        tick();
        ifc.soft_reset = 1'b0;
        repeat (5) tick();
        chk("to_reads", n_reads, 0);
        chk("to_abort", n_abort, 1);
        chk("to_err", err_count, 1);
        chk("to_busy", busy, 0);
        chk("to_done", n_done, 0);
        chk("to_rx", rx_log.size(), 0);

        // L=63 packet with a mid-body stall, then an L=1 packet back to back
        reset_dut();
        read_delay = 6'd1;
        push_pkt(8'hFD, 8'h01, 8'h03, 1'b0);
        push_pkt(8'h05, 8'hA5, 8'h00, 1'b0);
        ifc.vld_out = 1'b1;
        reads1 = -1;
        stalled = 1'b0;
        b = 0;
        while (n_done < 2 && b < 600) begin
            tick();
            b++;
            if (n_done >= 1 && reads1 < 0) reads1 = n_reads;
            if (n_reads == 20 && !stalled) begin
                stalled = 1'b1;
                stall = 1'b1;
                ifc.vld_out = 1'b0;
                repeat (10) tick();
                stall = 1'b0;
                ifc.vld_out = (fifo_q.size() != 0);
            end
        end
        repeat (3) tick();
        chk("b2b_reads_first", reads1, 65);
        chk("b2b_reads_second", n_reads - reads1, 3);
        chk("b2b_done", n_done, 2);
        chk("b2b_good", good_count, 2);
        chk("b2b_err", err_count, 0);
        chk("b2b_rx_count", rx_log.size(), exp_rx.size());
        for (int i = 0; i < exp_rx.size() && i < rx_log.size(); i++) chk("b2b_rx_byte", rx_log[i], exp_rx[i]);

        // Reset in the middle of BODY
        reset_dut();
        read_delay = 6'd0;
        push_pkt(8'h0D, 8'h11, 8'h11, 1'b0);
        ifc.vld_out = 1'b1;
        b = 0;
        while (n_reads < 3 && b < 50) begin
            tick();
            b++;
        end
        chk("mid_reached_body", n_reads, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        fifo_q.delete();
        ifc.vld_out = 1'b0;
        tick();
        chk("mid_read_enb", s_re, 0);
        chk("mid_rx_valid", s_rxv, 0);
        chk("mid_rx_data", s_rxd, 0);
        chk("mid_pkt_done", s_done, 0);
        chk("mid_pkt_abort", s_abort, 0);
        chk("mid_parity_err", s_par, 0);
        chk("mid_addr_err", s_addr, 0);
        chk("mid_pkt_len", s_len, 0);
        chk("mid_pkt_addr", s_paddr, 0);
        chk("mid_good", s_good, 0);
        chk("mid_err", s_err, 0);
        chk("mid_busy", s_busy, 0);
        repeat (3) tick();
        chk("mid_no_done", n_done, 0);
        chk("mid_no_abort", n_abort, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
        $fatal(1, "time limit");
    end
endmodule
